alu_exec: RTL and testbench

Pipelined execute unit that issues operations to the combinational `alu` and returns registered results over a valid/ready interface. It adds an internal accumulator so operation chains (a running sum, for example) need no software round trip. It sits between the future decode/issue logic and the `alu`, and drives the `alu` operand/opcode interface.

---
 rtl/alu_pkg.sv | 18 +
 rtl/alu.sv | 30 +++
 rtl/alu_exec.sv | 144 ++++++++++++++
 tb/tb_alu_exec.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encoding and execute-unit pipeline constants.
package alu_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_SLT = 3'd5,
        ALU_SLL = 3'd6,
        ALU_SRL = 3'd7
    } alu_op_t;

    localparam int ALU_W        = 32;
    localparam int ALU_EXEC_LAT = 2;

endpackage

// File: rtl/alu.sv
// Combinational 32-bit ALU with a zero flag; arithmetic wraps, SLT is signed.
module alu
    import alu_pkg::*;
(
    input  alu_op_t           op_i,
    input  logic [ALU_W-1:0]  a_i,
    input  logic [ALU_W-1:0]  b_i,
    output logic [ALU_W-1:0]  result_o,
    output logic              zero_o
);

    // Opcode decode into the result value
    always_comb begin
        result_o = 32'd0;
        case (op_i)
            ALU_ADD: result_o = a_i + b_i;
            ALU_SUB: result_o = a_i - b_i;
            ALU_AND: result_o = a_i & b_i;
            ALU_OR:  result_o = a_i | b_i;
            ALU_XOR: result_o = a_i ^ b_i;
            ALU_SLT: result_o = {31'd0, ($signed(a_i) < $signed(b_i))};
            ALU_SLL: result_o = a_i << b_i[4:0];
            ALU_SRL: result_o = a_i >> b_i[4:0];
            default: result_o = 32'd0;
        endcase
    end

    assign zero_o = (result_o == 32'd0);

endmodule

// File: rtl/alu_exec.sv
// Two-stage execute unit: S1 issues to the ALU, S2 holds the registered response.
// The accumulator is written on every S1->S2 transfer so use_acc ops chain back to back.
module alu_exec
    import alu_pkg::*;
#(
    parameter int TAG_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  alu_op_t           req_op,
    input  logic [ALU_W-1:0]  req_a,
    input  logic [ALU_W-1:0]  req_b,
    input  logic              req_use_acc,
    input  logic [TAG_W-1:0]  req_tag,
    input  logic              acc_clr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [ALU_W-1:0]  rsp_result,
    output logic              rsp_zero,
    output logic [TAG_W-1:0]  rsp_tag,
    output logic [ALU_W-1:0]  acc
);

    logic              s1_valid_q, s1_valid_d;
    alu_op_t           s1_op_q, s1_op_d;
    logic [ALU_W-1:0]  s1_a_q, s1_a_d;
    logic [ALU_W-1:0]  s1_b_q, s1_b_d;
    logic              s1_use_acc_q, s1_use_acc_d;
    logic [TAG_W-1:0]  s1_tag_q, s1_tag_d;

    logic              rsp_valid_q, rsp_valid_d;
    logic [ALU_W-1:0]  rsp_result_q, rsp_result_d;
    logic              rsp_zero_q, rsp_zero_d;
    logic [TAG_W-1:0]  rsp_tag_q, rsp_tag_d;
    logic [ALU_W-1:0]  acc_q, acc_d;

    logic              s2_free_s;
    logic              advance_s;
    logic              accept_s;
    logic [ALU_W-1:0]  alu_a_s;
    logic [ALU_W-1:0]  alu_res_s;
    logic              alu_zero_s;

    // Ready is purely a function of pipeline occupancy so it never waits on req_valid
    assign s2_free_s = !rsp_valid_q || rsp_ready;
    assign advance_s = s1_valid_q && s2_free_s;
    assign req_ready = rst_n && (!s1_valid_q || s2_free_s);
    assign accept_s  = req_valid && req_ready;
    assign alu_a_s   = s1_use_acc_q ? acc_q : s1_a_q;

    alu u_alu (
        .op_i     (s1_op_q),
        .a_i      (alu_a_s),
        .b_i      (s1_b_q),
        .result_o (alu_res_s),
        .zero_o   (alu_zero_s)
    );

    // Next-state for S1, S2 and the accumulator
    always_comb begin
        s1_valid_d   = s1_valid_q;
        s1_op_d      = s1_op_q;
        s1_a_d       = s1_a_q;
        s1_b_d       = s1_b_q;
        s1_use_acc_d = s1_use_acc_q;
        s1_tag_d     = s1_tag_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_result_d = rsp_result_q;
        rsp_zero_d   = rsp_zero_q;
        rsp_tag_d    = rsp_tag_q;
        acc_d        = acc_q;

        if (accept_s) begin
            s1_valid_d   = 1'b1;
            s1_op_d      = req_op;
            s1_a_d       = req_a;
            s1_b_d       = req_b;
            s1_use_acc_d = req_use_acc;
            s1_tag_d     = req_tag;
        end else if (advance_s) begin
            s1_valid_d = 1'b0;
        end else begin
            s1_valid_d = s1_valid_q;
        end

        if (advance_s) begin
            rsp_valid_d  = 1'b1;
            rsp_result_d = alu_res_s;
            rsp_zero_d   = alu_zero_s;
            rsp_tag_d    = s1_tag_q;
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end else begin
            rsp_valid_d = rsp_valid_q;
        end

        // A clear beats a coincident transfer; the result still goes out on rsp_result
        if (acc_clr) begin
            acc_d = 32'd0;
        end else if (advance_s) begin
            acc_d = alu_res_s;
        end else begin
            acc_d = acc_q;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q   <= 1'b0;
            s1_op_q      <= ALU_ADD;
            s1_a_q       <= 32'd0;
            s1_b_q       <= 32'd0;
            s1_use_acc_q <= 1'b0;
            s1_tag_q     <= {TAG_W{1'b0}};
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= 32'd0;
            rsp_zero_q   <= 1'b0;
            rsp_tag_q    <= {TAG_W{1'b0}};
            acc_q        <= 32'd0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_op_q      <= s1_op_d;
            s1_a_q       <= s1_a_d;
            s1_b_q       <= s1_b_d;
            s1_use_acc_q <= s1_use_acc_d;
            s1_tag_q     <= s1_tag_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_zero_q   <= rsp_zero_d;
            rsp_tag_q    <= rsp_tag_d;
            acc_q        <= acc_d;
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_zero   = rsp_zero_q;
    assign rsp_tag    = rsp_tag_q;
    assign acc        = acc_q;

endmodule

// File: tb/tb_alu_exec.sv
// Directed bench for alu_exec: table of single ops plus hand-written chain,
// backpressure, coincident-clear and mid-flight reset sequences.
module tb_alu_exec;
    import alu_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    alu_op_t     req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        req_use_acc;
    logic [3:0]  req_tag;
    logic        acc_clr;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_zero;
    logic [3:0]  rsp_tag;
    logic [31:0] acc;

    int total;
    int bad;

    typedef struct {
        alu_op_t     op;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  tag;
        logic [31:0] exp_res;
        logic        exp_zero;
    } vec_t;

    vec_t vecs [11];

    alu_exec #(.TAG_W(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_use_acc (req_use_acc),
        .req_tag     (req_tag),
        .acc_clr     (acc_clr),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_result  (rsp_result),
        .rsp_zero    (rsp_zero),
        .rsp_tag     (rsp_tag),
        .acc         (acc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input alu_op_t op, input logic [31:0] a, input logic [31:0] b,
                         input logic use_acc, input logic [3:0] tag);
        req_valid   = 1'b1;
        req_op      = op;
        req_a       = a;
        req_b       = b;
        req_use_acc = use_acc;
        req_tag     = tag;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        vecs[0]  = '{ALU_ADD, 32'd10,         32'd20,         4'd3,  32'd30,         1'b0};
        vecs[1]  = '{ALU_SUB, 32'd10,         32'd10,         4'd4,  32'd0,          1'b1};
        vecs[2]  = '{ALU_SLT, 32'hFFFF_FFFB,  32'd10,         4'd5,  32'd1,          1'b0};
        vecs[3]  = '{ALU_AND, 32'hFF00_FF00,  32'hFFFF_0000,  4'd6,  32'hFF00_0000,  1'b0};
        vecs[4]  = '{ALU_SLT, 32'd10,         32'hFFFF_FFFB,  4'd7,  32'd0,          1'b1};
        vecs[5]  = '{ALU_SUB, 32'd0,          32'd1,          4'd8,  32'hFFFF_FFFF,  1'b0};
        vecs[6]  = '{ALU_ADD, 32'hFFFF_FFFF,  32'd1,          4'd9,  32'd0,          1'b1};
        vecs[7]  = '{ALU_OR,  32'h0000_00F0,  32'h0000_000F,  4'd10, 32'h0000_00FF,  1'b0};
        vecs[8]  = '{ALU_XOR, 32'hAAAA_5555,  32'hFFFF_FFFF,  4'd11, 32'h5555_AAAA,  1'b0};
        vecs[9]  = '{ALU_SLL, 32'd1,          32'd31,         4'd12, 32'h8000_0000,  1'b0};
        vecs[10] = '{ALU_SRL, 32'h8000_0000,  32'd4,          4'd13, 32'h0800_0000,  1'b0};

        rst_n = 1'b0; req_valid = 1'b0; req_op = ALU_ADD; req_a = 32'd0; req_b = 32'd0;
        req_use_acc = 1'b0; req_tag = 4'd0; acc_clr = 1'b0; rsp_ready = 1'b1;
        tick();
        tick();
        chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("reset_rsp_result", rsp_result, 32'd0);
        chk("reset_acc", acc, 32'd0);
        chk("reset_req_ready", {31'd0, req_ready}, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("empty_req_ready", {31'd0, req_ready}, 32'd1);

        // table of single ops: accepted at edge N, response visible after edge N+1
        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, vecs[i].tag);
            #1;
            chk("vec_req_ready", {31'd0, req_ready}, 32'd1);
            tick();
            req_valid = 1'b0;
            chk("vec_lat_early", {31'd0, rsp_valid}, 32'd0);
            tick();
            chk("vec_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("vec_result", rsp_result, vecs[i].exp_res);
            chk("vec_zero", {31'd0, rsp_zero}, {31'd0, vecs[i].exp_zero});
            chk("vec_tag", {28'd0, rsp_tag}, {28'd0, vecs[i].tag});
        end
        tick();
        chk("drain_rsp_valid", {31'd0, rsp_valid}, 32'd0);

        // accumulate chain 5,7,9 back to back
        acc_clr = 1'b1;
        tick();
        acc_clr = 1'b0;
        chk("chain_clr_acc", acc, 32'd0);
        drive(ALU_ADD, 32'hDEAD_BEEF, 32'd5, 1'b1, 4'd1);
        #1;
        chk("chain_ready0", {31'd0, req_ready}, 32'd1);
        tick();
        chk("chain_rsp_empty", {31'd0, rsp_valid}, 32'd0);
        drive(ALU_ADD, 32'hDEAD_BEEF, 32'd7, 1'b1, 4'd2);
        #1;
        chk("chain_ready1", {31'd0, req_ready}, 32'd1);
        tick();
        chk("chain_res0", rsp_result, 32'd5);
        chk("chain_acc0", acc, 32'd5);
        drive(ALU_ADD, 32'hDEAD_BEEF, 32'd9, 1'b1, 4'd3);
        #1;
        chk("chain_ready2", {31'd0, req_ready}, 32'd1);
        tick();
        req_valid = 1'b0;
        chk("chain_res1", rsp_result, 32'd12);
        tick();
        chk("chain_res2", rsp_result, 32'd21);
        chk("chain_tag2", {28'd0, rsp_tag}, 32'd3);
        chk("chain_acc2", acc, 32'd21);
        tick();
        chk("chain_drained", {31'd0, rsp_valid}, 32'd0);

        // backpressure: two accepted, third refused until rsp_ready returns
        rsp_ready = 1'b0;
        drive(ALU_ADD, 32'd1, 32'd1, 1'b0, 4'd1);
        #1;
        chk("bp_ready_a", {31'd0, req_ready}, 32'd1);
        tick();
        drive(ALU_ADD, 32'd2, 32'd2, 1'b0, 4'd2);
        #1;
        chk("bp_ready_b", {31'd0, req_ready}, 32'd1);
        tick();
        drive(ALU_ADD, 32'd3, 32'd3, 1'b0, 4'd3);
        #1;
        chk("bp_full_ready", {31'd0, req_ready}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("bp_hold_valid", {31'd0, rsp_valid}, 32'd1);
            chk("bp_hold_result", rsp_result, 32'd2);
            chk("bp_hold_tag", {28'd0, rsp_tag}, 32'd1);
            chk("bp_hold_ready", {31'd0, req_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_release_ready", {31'd0, req_ready}, 32'd1);
        tick();
        req_valid = 1'b0;
        chk("bp_rsp_b", rsp_result, 32'd4);
        chk("bp_tag_b", {28'd0, rsp_tag}, 32'd2);
        tick();
        chk("bp_rsp_c", rsp_result, 32'd6);
        chk("bp_tag_c", {28'd0, rsp_tag}, 32'd3);
        chk("bp_valid_c", {31'd0, rsp_valid}, 32'd1);
        tick();
        chk("bp_no_dup", {31'd0, rsp_valid}, 32'd0);

        // clear coincident with a use_acc transfer: result delivered, acc cleared
        acc_clr = 1'b1;
        tick();
        acc_clr = 1'b0;
        drive(ALU_ADD, 32'd0, 32'd6, 1'b1, 4'd4);
        tick();
        req_valid = 1'b0;
        tick();
        chk("clr_acc_pre", acc, 32'd6);
        tick();
        drive(ALU_ADD, 32'd0, 32'd4, 1'b1, 4'd5);
        tick();
        req_valid = 1'b0;
        acc_clr   = 1'b1;
        tick();
        acc_clr = 1'b0;
        chk("clr_rsp_result", rsp_result, 32'd10);
        chk("clr_acc_post", acc, 32'd0);
        tick();

        // reset with two ops in flight
        rsp_ready = 1'b0;
        drive(ALU_ADD, 32'd1, 32'd2, 1'b0, 4'd6);
        tick();
        drive(ALU_ADD, 32'd3, 32'd4, 1'b0, 4'd7);
        tick();
        req_valid = 1'b0;
        chk("rst_inflight_valid", {31'd0, rsp_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_req_ready_low", {31'd0, req_ready}, 32'd0);
        tick();
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_result", rsp_result, 32'd0);
        chk("rst_rsp_zero", {31'd0, rsp_zero}, 32'd0);
        chk("rst_rsp_tag", {28'd0, rsp_tag}, 32'd0);
        chk("rst_acc", acc, 32'd0);
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("rst_no_rsp", {31'd0, rsp_valid}, 32'd0);
        end
        drive(ALU_ADD, 32'd7, 32'd8, 1'b0, 4'd5);
        tick();
        req_valid = 1'b0;
        tick();
        chk("post_rst_valid", {31'd0, rsp_valid}, 32'd1);
        chk("post_rst_result", rsp_result, 32'd15);
        chk("post_rst_tag", {28'd0, rsp_tag}, 32'd5);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
